// File: rtl/dispense_controller.sv
// dispense_controller
//   Downstream stage of the vending FSM. Turns one-cycle product/change
//   request pulses into timed, mutually exclusive actuator drives (three
//   product motors and one coin-return solenoid). Requests are held in a
//   pending register and serviced one at a time, A > B > C > change.
//
// Optional feature macro: DISPENSE_STOCK_EN
//   Defined   : per-product stock counters, sold-out refund path, restock,
//               sold* flags.
//   Undefined : no counters, sold* tied low, restock ignored.
//
// Ports
//   clk                 : rising-edge clock
//   reset               : synchronous, active-high
//   PrA/PrB/PrC/change  : one-cycle request pulses
//   restock             : one-cycle pulse, reloads all stock counters
//   motA/motB/motC      : product motor drives (registered)
//   coin_ret            : coin-return solenoid drive (registered)
//   busy                : state not idle or any request pending
//   overrun             : one-cycle pulse when a request is dropped
//   soldA/soldB/soldC   : high while that product's stock is zero
module dispense_controller #(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned STOCK_INIT   = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic PrA,
  input  logic PrB,
  input  logic PrC,
  input  logic change,
  input  logic restock,
  output logic motA,
  output logic motB,
  output logic motC,
  output logic coin_ret,
  output logic busy,
  output logic overrun,
  output logic soldA,
  output logic soldB,
  output logic soldC
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  localparam logic [7:0] LP_DRIVE_LOAD = 8'(MOTOR_CYCLES - 1);
  localparam logic [7:0] LP_GAP_LOAD   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam bit         LP_NO_GAP     = (GAP_CYCLES == 0);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_timer, w_timer_nxt;
  logic [3:0] r_pend,  w_pend_nxt;
  logic [3:0] r_out,   w_out_nxt;
  logic       r_overrun, w_overrun_nxt;

  logic [3:0] w_in;
  logic [3:0] w_cand;
  logic [3:0] w_win;
  logic [3:0] w_drive;
  logic [3:0] w_clr;
  logic [2:0] w_empty;
  logic       w_slot;
  logic       w_start;

  // Bit order throughout: [0]=A, [1]=B, [2]=C, [3]=change.
  assign w_in   = {change, PrC, PrB, PrA};
  assign w_cand = r_pend | w_in;
  // Isolate the lowest set bit: gives the A > B > C > CHG priority.
  assign w_win  = w_cand & (~w_cand + 4'd1);

  // A sold-out product winner is served as a refund on the coin solenoid.
  assign w_drive = (|(w_win[2:0] & w_empty)) ? 4'b1000 : w_win;

  // A new service may start from IDLE, at the end of GAP, or straight out
  // of DRIVE when there is no dead time.
  assign w_slot  = (r_state == ST_IDLE) ||
                   ((r_timer == '0) &&
                    ((r_state == ST_GAP) || ((r_state == ST_DRIVE) && LP_NO_GAP)));
  assign w_start = w_slot && (w_cand != '0);
  assign w_clr   = w_start ? w_win : '0;

  // A served bit that was already pending is re-armed by a same-cycle pulse;
  // a served bit that came straight from the input is consumed.
  assign w_pend_nxt    = (w_clr & r_pend & w_in) | (~w_clr & (r_pend | w_in));
  assign w_overrun_nxt = |(w_in & r_pend & ~w_clr);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_out_nxt   = r_out;
    case (r_state)
      ST_DRIVE: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - 8'd1;
        end else if (!LP_NO_GAP) begin
          w_state_nxt = ST_GAP;
          w_timer_nxt = LP_GAP_LOAD;
          w_out_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (r_timer != '0) begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      default: ;
    endcase
    if (w_slot) begin
      if (w_start) begin
        w_state_nxt = ST_DRIVE;
        w_timer_nxt = LP_DRIVE_LOAD;
        w_out_nxt   = w_drive;
      end else begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_out_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_pend    <= '0;
      r_out     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_pend    <= w_pend_nxt;
      r_out     <= w_out_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

`ifdef DISPENSE_STOCK_EN
  localparam logic [CNT_W-1:0] LP_STOCK_INIT = CNT_W'(STOCK_INIT);
  localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

  logic [CNT_W-1:0] r_stock [3];

  always_comb begin
    w_empty = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_empty[i] = (r_stock[i] == '0);
    end
  end

  // Restock overrides a same-cycle decrement; an empty counter is never
  // decremented because that winner is turned into a refund instead.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (reset || restock) begin
        r_stock[i] <= LP_STOCK_INIT;
      end else if (w_start && w_win[i] && !w_empty[i]) begin
        r_stock[i] <= r_stock[i] - LP_ONE;
      end
    end
  end

  assign soldA = w_empty[0];
  assign soldB = w_empty[1];
  assign soldC = w_empty[2];
`else
  logic [32:0] w_unused_cfg;
  assign w_unused_cfg = {restock, 32'(CNT_W + STOCK_INIT)};
  assign w_empty = '0;
  assign soldA   = 1'b0;
  assign soldB   = 1'b0;
  assign soldC   = 1'b0;
`endif

  assign motA     = r_out[0];
  assign motB     = r_out[1];
  assign motC     = r_out[2];
  assign coin_ret = r_out[3];
  assign overrun  = r_overrun;
  assign busy     = (r_state != ST_IDLE) || (r_pend != '0);

  a_excl: assert property (@(posedge clk) disable iff (reset) $onehot0(r_out));

endmodule
